// File: rtl/ga_pkg.sv
// ga_pkg: types shared across the GA selection datapath.
//
// Holds the default chromosome type used by pop_pair_streamer, fitness_function
// and get_best, and the state encoding of the population streamer.

package ga_pkg;

    // Default chromosome width. Blocks that take a CHROM_WIDTH parameter
    // should keep it equal to this so chrom_t stays meaningful between them.
    localparam int DEFAULT_CHROM_WIDTH = 8;

    typedef logic [DEFAULT_CHROM_WIDTH-1:0] chrom_t;

    // IDLE   : loading / clearing allowed, waiting for start
    // STREAM : presenting pairs on the valid/ready interface
    // DONE   : single cycle after the final handshake, done pulses here
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/pop_ram.sv
// pop_ram: population storage, one write port and two asynchronous read ports.
//
// Ports:
//   clk        - write clock
//   wr_en      - write strobe, stores wr_data at wr_addr on the rising edge
//   wr_addr    - write address
//   wr_data    - chromosome to store
//   rd_addr_a  - address of the first chromosome of a pair
//   rd_data_a  - combinational read of rd_addr_a
//   rd_addr_b  - address of the second chromosome of a pair
//   rd_data_b  - combinational read of rd_addr_b
//
// No reset: contents are meaningless until written and are only ever read
// below the occupancy count kept by the owner.

module pop_ram #(
    parameter int CHROM_WIDTH = 8,
    parameter int POP_SIZE    = 16,
    parameter int ADDR_WIDTH  = $clog2(POP_SIZE)
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [ADDR_WIDTH-1:0]  wr_addr,
    input  logic [CHROM_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0]  rd_addr_a,
    output logic [CHROM_WIDTH-1:0] rd_data_a,
    input  logic [ADDR_WIDTH-1:0]  rd_addr_b,
    output logic [CHROM_WIDTH-1:0] rd_data_b
);

    logic [CHROM_WIDTH-1:0] mem [POP_SIZE];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = mem[rd_addr_a];
    assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/pop_pair_streamer.sv
// pop_pair_streamer: population buffer feeding the selection datapath.
//
// Chromosomes are appended one per cycle while idle. On start the stored
// population is streamed as (chrom1, chrom2) pairs over a valid/ready
// handshake. Contents persist afterwards, so another start replays them.
//
// Ports:
//   clk, reset     - clock; asynchronous active-low reset
//   clear          - empty the buffer (idle only)
//   load_valid     - load_data is valid
//   load_data      - chromosome to append
//   load_ready     - buffer accepts data (idle and not full)
//   start          - begin streaming (needs at least one chromosome)
//   busy           - streaming or in the done cycle
//   chrom1/chrom2  - current pair; chrom2 is 0 when enable_second is low
//   enable_second  - chrom2 carries a real chromosome
//   pair_valid     - pair outputs valid
//   pair_ready     - downstream accepts the pair
//   last           - current pair is the final one
//   done           - one-cycle pulse after the final handshake
//   count          - number of chromosomes stored

module pop_pair_streamer
    import ga_pkg::*;
#(
    parameter int CHROM_WIDTH = 8,
    parameter int POP_SIZE    = 16,
    parameter int CNT_WIDTH   = $clog2(POP_SIZE + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   load_valid,
    input  logic [CHROM_WIDTH-1:0] load_data,
    output logic                   load_ready,
    input  logic                   start,
    output logic                   busy,
    output logic [CHROM_WIDTH-1:0] chrom1,
    output logic [CHROM_WIDTH-1:0] chrom2,
    output logic                   enable_second,
    output logic                   pair_valid,
    input  logic                   pair_ready,
    output logic                   last,
    output logic                   done,
    output logic [CNT_WIDTH-1:0]   count
);

    localparam int ADDR_WIDTH = (POP_SIZE > 1) ? $clog2(POP_SIZE) : 1;
    localparam logic [CNT_WIDTH-1:0] POP_MAX = CNT_WIDTH'(POP_SIZE);
    localparam logic [CNT_WIDTH:0]   ONE     = (CNT_WIDTH + 1)'(1);
    localparam logic [CNT_WIDTH:0]   TWO     = (CNT_WIDTH + 1)'(2);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic [CNT_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CHROM_WIDTH-1:0] chrom1_q, chrom1_d;
    logic [CHROM_WIDTH-1:0] chrom2_q, chrom2_d;
    logic                   es_q, es_d;
    logic                   pv_q, pv_d;
    logic                   last_q, last_d;

    logic [CNT_WIDTH-1:0]   pair_idx;
    logic [CNT_WIDTH:0]     pair_idx_ext;
    logic [CNT_WIDTH:0]     count_ext;
    logic                   has_second;
    logic                   is_last;
    logic                   wr_en;
    logic [CHROM_WIDTH-1:0] rd_data_a, rd_data_b;

    // The pair being fetched: pair 0 when launching from IDLE, otherwise the
    // element index held in rd_ptr (always even, points past the shown pair).
    assign pair_idx     = (state_q == IDLE) ? '0 : rd_ptr_q;
    assign pair_idx_ext = {1'b0, pair_idx};
    assign count_ext    = {1'b0, count_q};
    assign has_second   = (pair_idx_ext + ONE) < count_ext;
    assign is_last      = (pair_idx_ext + TWO) >= count_ext;

    pop_ram #(
        .CHROM_WIDTH (CHROM_WIDTH),
        .POP_SIZE    (POP_SIZE),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_ram (
        .clk       (clk),
        .wr_en     (wr_en),
        .wr_addr   (count_q[ADDR_WIDTH-1:0]),
        .wr_data   (load_data),
        .rd_addr_a (pair_idx[ADDR_WIDTH-1:0]),
        .rd_data_a (rd_data_a),
        .rd_addr_b (ADDR_WIDTH'(pair_idx_ext + ONE)),
        .rd_data_b (rd_data_b)
    );

    // State, occupancy, read pointer and the registered pair outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rd_ptr_q <= '0;
            chrom1_q <= '0;
            chrom2_q <= '0;
            es_q     <= 1'b0;
            pv_q     <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            chrom1_q <= chrom1_d;
            chrom2_q <= chrom2_d;
            es_q     <= es_d;
            pv_q     <= pv_d;
            last_q   <= last_d;
        end
    end

    // Next-state and next-output logic. An accepted start takes priority over
    // clear and load in the same cycle; clear takes priority over load.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        chrom1_d = chrom1_q;
        chrom2_d = chrom2_q;
        es_d     = es_q;
        pv_d     = pv_q;
        last_d   = last_q;
        wr_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && (count_q != '0)) begin
                    state_d  = STREAM;
                    chrom1_d = rd_data_a;
                    chrom2_d = has_second ? rd_data_b : '0;
                    es_d     = has_second;
                    last_d   = is_last;
                    pv_d     = 1'b1;
                    rd_ptr_d = CNT_WIDTH'(pair_idx_ext + TWO);
                end else if (clear) begin
                    count_d = '0;
                end else if (load_valid && load_ready) begin
                    wr_en   = 1'b1;
                    count_d = CNT_WIDTH'(count_ext + ONE);
                end
            end
            STREAM: begin
                if (pv_q && pair_ready) begin
                    if (last_q) begin
                        state_d  = DONE;
                        chrom1_d = '0;
                        chrom2_d = '0;
                        es_d     = 1'b0;
                        pv_d     = 1'b0;
                        last_d   = 1'b0;
                    end else begin
                        chrom1_d = rd_data_a;
                        chrom2_d = has_second ? rd_data_b : '0;
                        es_d     = has_second;
                        last_d   = is_last;
                        rd_ptr_d = CNT_WIDTH'(pair_idx_ext + TWO);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign load_ready    = (state_q == IDLE) && (count_q < POP_MAX);
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign chrom1        = chrom1_q;
    assign chrom2        = chrom2_q;
    assign enable_second = es_q;
    assign pair_valid    = pv_q;
    assign last          = last_q;
    assign count         = count_q;

endmodule

// File: tb/tb_pop_pair_streamer.sv
// tb_pop_pair_streamer: directed, self-checking bench for pop_pair_streamer.
//
// Inputs change on the falling clock edge and outputs are sampled there too,
// half a cycle away from the rising edge that updates the DUT.

module tb_pop_pair_streamer;

    typedef struct {
        logic       lv;
        logic [7:0] ld;
        logic       clr;
        logic       st;
        logic       exp_ready;
        logic [4:0] exp_count;
    } vec_t;

    typedef struct {
        logic [7:0] c1;
        logic [7:0] c2;
        logic       es;
        logic       last;
    } pair_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic       start;
    logic       busy;
    logic [7:0] chrom1;
    logic [7:0] chrom2;
    logic       enable_second;
    logic       pair_valid;
    logic       pair_ready;
    logic       last;
    logic       done;
    logic [4:0] count;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pop_pair_streamer #(
        .CHROM_WIDTH (8),
        .POP_SIZE    (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_ready    (load_ready),
        .start         (start),
        .busy          (busy),
        .chrom1        (chrom1),
        .chrom2        (chrom2),
        .enable_second (enable_second),
        .pair_valid    (pair_valid),
        .pair_ready    (pair_ready),
        .last          (last),
        .done          (done),
        .count         (count)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One idle-phase cycle from the control table.
    task automatic apply_stimulus(input vec_t v, input string tag);
        load_valid = v.lv;
        load_data  = v.ld;
        clear      = v.clr;
        start      = v.st;
        @(negedge clk);
        load_valid = 1'b0;
        clear      = 1'b0;
        start      = 1'b0;
        check_output({tag, " count"}, 32'(count), 32'(v.exp_count));
        check_output({tag, " load_ready"}, 32'(load_ready), 32'(v.exp_ready));
        check_output({tag, " busy"}, 32'(busy), 32'd0);
        check_output({tag, " pair_valid"}, 32'(pair_valid), 32'd0);
    endtask

    task automatic load_values(input logic [7:0] vals[$]);
        foreach (vals[i]) begin
            load_valid = 1'b1;
            load_data  = vals[i];
            @(negedge clk);
        end
        load_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Starts a stream with pair_ready held high and checks every pair, the
    // done cycle and the return to idle. Optionally pulses start again while
    // the first pair is shown. load_valid is left as the caller set it for
    // the start cycle only.
    task automatic stream_check(input pair_t exp[$], input string tag, input bit extra_start);
        pair_ready = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        load_valid = 1'b0;
        foreach (exp[k]) begin
            check_output($sformatf("%s pair%0d valid", tag, k), 32'(pair_valid), 32'd1);
            check_output($sformatf("%s pair%0d chrom1", tag, k), 32'(chrom1), 32'(exp[k].c1));
            check_output($sformatf("%s pair%0d chrom2", tag, k), 32'(chrom2), 32'(exp[k].c2));
            check_output($sformatf("%s pair%0d es", tag, k), 32'(enable_second), 32'(exp[k].es));
            check_output($sformatf("%s pair%0d last", tag, k), 32'(last), 32'(exp[k].last));
            check_output($sformatf("%s pair%0d busy", tag, k), 32'(busy), 32'd1);
            check_output($sformatf("%s pair%0d done", tag, k), 32'(done), 32'd0);
            if (extra_start && k == 0) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        check_output({tag, " done-cycle valid"}, 32'(pair_valid), 32'd0);
        check_output({tag, " done-cycle done"}, 32'(done), 32'd1);
        check_output({tag, " done-cycle busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        check_output({tag, " after done"}, 32'(done), 32'd0);
        check_output({tag, " after busy"}, 32'(busy), 32'd0);
        check_output({tag, " after valid"}, 32'(pair_valid), 32'd0);
    endtask

    initial begin
        pair_t t1[$];
        pair_t t2[$];
        pair_t t4[$];
        vec_t  fill_tab[$];
        vec_t  ctrl_tab[$];

        // Expected pair sequences and control tables.
        t1 = '{'{8'h11, 8'h22, 1'b1, 1'b0}, '{8'h33, 8'h44, 1'b1, 1'b1}};
        t2 = '{'{8'hA1, 8'hB2, 1'b1, 1'b0}, '{8'hC3, 8'h00, 1'b0, 1'b1}};
        for (int k = 0; k < 8; k++) begin
            t4.push_back('{8'(8'h40 + 2 * k), 8'(8'h41 + 2 * k), 1'b1, (k == 7)});
        end
        for (int i = 0; i < 16; i++) begin
            fill_tab.push_back('{1'b1, 8'(8'h40 + i), 1'b0, 1'b0, (i < 15), 5'(i + 1)});
        end
        fill_tab.push_back('{1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 5'd16});
        ctrl_tab = '{
            '{1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 5'd0},
            '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 5'd0},
            '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0},
            '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 5'd1},
            '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0}
        };

        reset      = 1'b0;
        clear      = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        start      = 1'b0;
        pair_ready = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check_output("reset pair_valid", 32'(pair_valid), 32'd0);
        check_output("reset busy", 32'(busy), 32'd0);
        check_output("reset done", 32'(done), 32'd0);
        check_output("reset count", 32'(count), 32'd0);
        check_output("reset last", 32'(last), 32'd0);
        check_output("reset es", 32'(enable_second), 32'd0);
        check_output("reset chrom1", 32'(chrom1), 32'd0);
        check_output("reset chrom2", 32'(chrom2), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_output("post-reset load_ready", 32'(load_ready), 32'd1);

        // Even population, back-to-back pairs, count preserved.
        load_values('{8'h11, 8'h22, 8'h33, 8'h44});
        check_output("t1 count", 32'(count), 32'd4);
        stream_check(t1, "t1", 1'b0);
        check_output("t1 count kept", 32'(count), 32'd4);

        // start and load in the same cycle: start wins, data dropped.
        load_valid = 1'b1;
        load_data  = 8'h99;
        stream_check(t1, "start+load", 1'b0);
        check_output("start+load count", 32'(count), 32'd4);

        // start while streaming is ignored; then a plain replay.
        stream_check(t1, "start-busy", 1'b1);
        stream_check(t1, "replay", 1'b0);

        // Odd population: final pair has no second chromosome.
        do_clear();
        load_values('{8'hA1, 8'hB2, 8'hC3});
        check_output("t2 count", 32'(count), 32'd3);
        stream_check(t2, "t2", 1'b0);

        // Backpressure: outputs hold while pair_ready is low.
        do_clear();
        load_values('{8'h01, 8'h02, 8'h03, 8'h04});
        pair_ready = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_output($sformatf("bp hold%0d valid", i), 32'(pair_valid), 32'd1);
            check_output($sformatf("bp hold%0d chrom1", i), 32'(chrom1), 32'h01);
            check_output($sformatf("bp hold%0d chrom2", i), 32'(chrom2), 32'h02);
            check_output($sformatf("bp hold%0d last", i), 32'(last), 32'd0);
            @(negedge clk);
        end
        check_output("bp still pair0", 32'(chrom1), 32'h01);
        pair_ready = 1'b1;
        @(negedge clk);
        check_output("bp pair1 chrom1", 32'(chrom1), 32'h03);
        check_output("bp pair1 chrom2", 32'(chrom2), 32'h04);
        check_output("bp pair1 last", 32'(last), 32'd1);
        check_output("bp pair1 valid", 32'(pair_valid), 32'd1);
        @(negedge clk);
        check_output("bp done", 32'(done), 32'd1);
        check_output("bp valid drop", 32'(pair_valid), 32'd0);
        @(negedge clk);

        // Fill to capacity, overflow write dropped, 8 pairs streamed.
        do_clear();
        foreach (fill_tab[i]) apply_stimulus(fill_tab[i], $sformatf("fill%0d", i));
        stream_check(t4, "full", 1'b0);
        check_output("full count kept", 32'(count), 32'd16);

        // clear vs load, start with empty buffer, load then clear.
        foreach (ctrl_tab[i]) apply_stimulus(ctrl_tab[i], $sformatf("ctrl%0d", i));

        // Asynchronous reset during pair 1.
        load_values('{8'h11, 8'h22, 8'h33, 8'h44});
        pair_ready = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_output("rst pair1 chrom1", 32'(chrom1), 32'h33);
        pair_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_output("rst valid", 32'(pair_valid), 32'd0);
        check_output("rst busy", 32'(busy), 32'd0);
        check_output("rst count", 32'(count), 32'd0);
        check_output("rst done", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output($sformatf("rst held done%0d", i), 32'(done), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        check_output("rst release load_ready", 32'(load_ready), 32'd1);
        check_output("rst release done", 32'(done), 32'd0);
        check_output("rst release busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pop_pair_streamer.md
Name: pop_pair_streamer

Overview:
Population buffer that feeds the selection datapath. It accepts up to POP_SIZE chromosomes one per cycle, then on start streams them out as (chrom1, chrom2) pairs with a valid/ready handshake. It is the source end of the pairwise chrom1/chrom2/enable_second interface consumed by fitness_function and get_best. The buffer contents persist after a stream, so the same population can be replayed.

Parameters:
CHROM_WIDTH, 8, chromosome width in bits
POP_SIZE, 16, buffer depth in chromosomes; must be ≥2
CNT_WIDTH, $clog2(POP_SIZE+1), width of the occupancy count

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
clear  in  1  synchronous; empties the buffer (count←0); ignored while busy
load_valid  in  1  load_data is valid this cycle
load_data  in  CHROM_WIDTH  chromosome to append
load_ready  out  1  buffer can accept data: IDLE and count<POP_SIZE
start  in  1  begin streaming the current population
busy  out  1  high from the cycle after an accepted start until done
chrom1  out  CHROM_WIDTH  first chromosome of the pair
chrom2  out  CHROM_WIDTH  second chromosome of the pair; 0 when enable_second=0
enable_second  out  1  chrom2 is meaningful
pair_valid  out  1  pair outputs are valid
pair_ready  in  1  downstream accepts the pair
last  out  1  the current pair is the final one of the stream
done  out  1  one-cycle pulse after the final pair handshake
count  out  CNT_WIDTH  number of chromosomes stored

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; count, read pointer, chrom1, chrom2, enable_second, pair_valid, last, done and busy all 0. Memory contents are don't-care.
- States:
  - IDLE→STREAM when start=1 and count≥1.
  - STREAM→DONE on the handshake (pair_valid & pair_ready) of the pair with last=1.
  - DONE→IDLE unconditionally after 1 cycle. done=1 only in DONE.
- Load (IDLE only): a write occurs when load_valid & load_ready. It stores mem[count]←load_data and count+1. With count=POP_SIZE, load_ready=0 and load_valid is ignored. There is no wrap-around.
- clear in IDLE sets count←0 the next cycle. If clear and load_valid are both high, clear wins and the data is dropped.
- start with count=0 is ignored and the block stays IDLE.
- If start and load_valid are both high in IDLE, start wins and the data is not written. load_ready is 0 in every state other than IDLE.
- start while busy is ignored.
- Pairing: pair k = (mem[2k], mem[2k+1]) for k = 0..ceil(count/2)−1.
  - For odd count, the final pair has enable_second=0 and chrom2=0.
  - last=1 only on pair ceil(count/2)−1.
- Timing and handshake:
  - start accepted in cycle t → pair 0 valid at t+1 (registered outputs).
  - Outputs are held stable while pair_valid & !pair_ready.
  - On a handshake the next pair appears in the next cycle with pair_valid kept high, giving one pair per cycle under a constant pair_ready.
  - After the last handshake, pair_valid drops in the next cycle, which is also the DONE cycle.
- busy=1 in STREAM and DONE.
- count is unchanged by streaming. A replay of the same population needs only another start.
- Reset mid-stream aborts immediately: pair_valid=0, no done pulse, count=0.

Decomposition:
- Package ga_pkg holds the shared chromosome type: typedef logic [CHROM_WIDTH-1:0] chrom_t, default CHROM_WIDTH=8, shared with get_best and fitness_function. It also holds the state enum {IDLE, STREAM, DONE}.
- One natural sub-module: pop_ram, a 1-write/2-read register array of POP_SIZE×CHROM_WIDTH with asynchronous read. The FSM, counters and output registers live in the top level.

Test Plan:
1. Reset, load 0x11,0x22,0x33,0x44, start with pair_ready=1 → (0x11,0x22,es=1,last=0), then (0x33,0x44,es=1,last=1) on consecutive cycles; done pulses once; count stays 4.
2. Load 0xA1,0xB2,0xC3 (odd), start → (0xA1,0xB2,es=1), then (0xC3,0x00,es=0,last=1); done follows.
3. Backpressure: 4 chromosomes, hold pair_ready=0 for 3 cycles after pair_valid rises → outputs stable across all 3 cycles; pairs resume in order once ready=1.
4. Full/boundary: with POP_SIZE=16, write 17 values → load_ready=0 after the 16th; 17th not stored; count=16; stream yields 8 pairs. Then start with count=0 after clear → busy stays 0 and no pair_valid.
5. Simultaneous events: start and load_valid in the same IDLE cycle → data dropped and count unchanged. start while streaming → ignored. A second start after done → identical pair sequence replayed.
6. Reset mid-stream: assert reset=0 asynchronously, between clock edges, during pair 1 → pair_valid, busy and count go to 0 immediately; no done pulse; load_ready=1 after release.
